// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Hazard controller for an in-order pipeline. Tracks, per pipeline register
//   1..NUM_REGS-1, what the instruction in that register will write. From that
//   shadow scoreboard and the instruction in ID it decides load-use stalls,
//   branch flushes, memory freezes and operand forwarding. It also keeps two
//   saturating performance counters.
//
// Ports
//   clk                      system clock, rising edge
//   rst                      asynchronous reset, active low
//   id_valid                 ID stage holds a valid instruction
//   id_rs1_idx/id_rs2_idx    ID source register indices
//   id_rs1_used/id_rs2_used  the corresponding source is actually read
//   id_rd_idx                ID destination register index
//   id_reg_wr                ID instruction writes a register
//   id_rd_mem                ID instruction is a load
//   br_take                  instruction in register BR_REG is a taken branch
//   mem_busy                 data memory not ready, freeze the pipeline
//   pc_enable                PC update enable
//   reg_enable[k]            load enable of pipeline register k
//   reg_bubble[k]            load a NOP into pipeline register k
//   fwd_sel_a/fwd_sel_b      0 = register file, k = result of pipeline reg k
//   stall_cnt/flush_cnt      saturating load-use stall / applied flush counts
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int unsigned NUM_REGS = 4,
    parameter int unsigned IDX_W    = 5,
    parameter int unsigned BR_REG   = 2,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        id_valid,
    input  logic [IDX_W-1:0]            id_rs1_idx,
    input  logic [IDX_W-1:0]            id_rs2_idx,
    input  logic                        id_rs1_used,
    input  logic                        id_rs2_used,
    input  logic [IDX_W-1:0]            id_rd_idx,
    input  logic                        id_reg_wr,
    input  logic                        id_rd_mem,
    input  logic                        br_take,
    input  logic                        mem_busy,
    output logic                        pc_enable,
    output logic [NUM_REGS-1:0]         reg_enable,
    output logic [NUM_REGS-1:0]         reg_bubble,
    output logic [$clog2(NUM_REGS):0]   fwd_sel_a,
    output logic [$clog2(NUM_REGS):0]   fwd_sel_b,
    output logic [CNT_W-1:0]            stall_cnt,
    output logic [CNT_W-1:0]            flush_cnt
);

    localparam int unsigned FWD_W = $clog2(NUM_REGS) + 1;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] rd;
        logic             reg_wr;
        logic             rd_mem;
    } sb_entry_t;

    sb_entry_t        sb_q [1:NUM_REGS-1];
    sb_entry_t        sb_d [1:NUM_REGS-1];
    logic             flush_pend_q, flush_pend_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic             freeze;
    logic             flush;
    logic             stall;
    logic             load_use;

    function automatic logic is_src(input sb_entry_t e);
        return e.valid && e.reg_wr && (e.rd != '0);
    endfunction

    // Event priority: freeze > flush > load-use stall. While rst is low all
    // events are masked so the outputs sit at their idle values.
    always_comb begin
        load_use = 1'b0;
        if (id_valid && is_src(sb_q[1]) && sb_q[1].rd_mem) begin
            load_use = (id_rs1_used && (id_rs1_idx == sb_q[1].rd)) ||
                       (id_rs2_used && (id_rs2_idx == sb_q[1].rd));
        end
        freeze = rst && mem_busy;
        // A branch seen during a freeze is remembered so it is applied once
        // the freeze lifts, even if br_take has dropped by then.
        flush  = rst && !mem_busy && (br_take || flush_pend_q);
        stall  = rst && !mem_busy && !flush && load_use;

        pc_enable  = !freeze && !stall;
        reg_enable = '1;
        reg_bubble = '0;
        if (freeze) begin
            reg_enable = '0;
        end else if (flush) begin
            for (int unsigned k = 0; k < BR_REG; k++) begin
                reg_bubble[k] = 1'b1;
            end
        end else if (stall) begin
            reg_enable[0] = 1'b0;
            reg_bubble[1] = 1'b1;
        end
    end

    // Youngest producer wins; a load still in register 1 has no data yet.
    always_comb begin
        logic found_a;
        logic found_b;
        fwd_sel_a = '0;
        fwd_sel_b = '0;
        found_a   = 1'b0;
        found_b   = 1'b0;
        for (int unsigned k = 1; k < NUM_REGS; k++) begin
            if (is_src(sb_q[k]) && !(k == 1 && sb_q[k].rd_mem)) begin
                if (!found_a && (sb_q[k].rd == id_rs1_idx)) begin
                    fwd_sel_a = FWD_W'(k);
                    found_a   = 1'b1;
                end
                if (!found_b && (sb_q[k].rd == id_rs2_idx)) begin
                    fwd_sel_b = FWD_W'(k);
                    found_b   = 1'b1;
                end
            end
        end
        if (!id_valid || !id_rs1_used || (id_rs1_idx == '0)) begin
            fwd_sel_a = '0;
        end
        if (!id_valid || !id_rs2_used || (id_rs2_idx == '0)) begin
            fwd_sel_b = '0;
        end
    end

    // Scoreboard shadows the pipeline registers using the same enables and
    // bubbles that are sent to the datapath.
    always_comb begin
        for (int unsigned k = 1; k < NUM_REGS; k++) begin
            sb_d[k] = sb_q[k];
        end
        if (reg_enable[1]) begin
            if (reg_bubble[1]) begin
                sb_d[1] = '0;
            end else begin
                sb_d[1] = '{valid: id_valid, rd: id_rd_idx,
                            reg_wr: id_reg_wr, rd_mem: id_rd_mem};
            end
        end
        for (int unsigned k = 2; k < NUM_REGS; k++) begin
            if (reg_enable[k]) begin
                sb_d[k] = reg_bubble[k] ? '0 : sb_q[k-1];
            end
        end

        flush_pend_d = mem_busy ? (flush_pend_q || br_take) : 1'b0;

        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        flush_cnt_d = flush_cnt_q;
        if (flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned k = 1; k < NUM_REGS; k++) begin
                sb_q[k] <= '0;
            end
            flush_pend_q <= 1'b0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            for (int unsigned k = 1; k < NUM_REGS; k++) begin
                sb_q[k] <= sb_d[k];
            end
            flush_pend_q <= flush_pend_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Directed bench for pipe_hazard_ctrl (NUM_REGS=4, BR_REG=2, CNT_W=4).
//   A pipeline-occupancy model predicts every output at each falling edge;
//   hand-computed literals pin the key scenarios.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam int NR  = 4;
    localparam int IW  = 5;
    localparam int BR  = 2;
    localparam int CW  = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid;
    logic [IW-1:0] id_rs1_idx, id_rs2_idx, id_rd_idx;
    logic          id_rs1_used, id_rs2_used, id_reg_wr, id_rd_mem;
    logic          br_take, mem_busy;
    logic          pc_enable;
    logic [NR-1:0] reg_enable, reg_bubble;
    logic [2:0]    fwd_sel_a, fwd_sel_b;
    logic [CW-1:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .NUM_REGS(NR),
        .IDX_W   (IW),
        .BR_REG  (BR),
        .CNT_W   (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_rs1_idx (id_rs1_idx),
        .id_rs2_idx (id_rs2_idx),
        .id_rs1_used(id_rs1_used),
        .id_rs2_used(id_rs2_used),
        .id_rd_idx  (id_rd_idx),
        .id_reg_wr  (id_reg_wr),
        .id_rd_mem  (id_rd_mem),
        .br_take    (br_take),
        .mem_busy   (mem_busy),
        .pc_enable  (pc_enable),
        .reg_enable (reg_enable),
        .reg_bubble (reg_bubble),
        .fwd_sel_a  (fwd_sel_a),
        .fwd_sel_b  (fwd_sel_b),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
    );

    int total = 0;
    int bad   = 0;

    // What occupies pipeline registers 1..NR-1 (current and next cycle).
    int m_v [1:NR-1], m_rd [1:NR-1], m_wr [1:NR-1], m_ld [1:NR-1];
    int n_v [1:NR-1], n_rd [1:NR-1], n_wr [1:NR-1], n_ld [1:NR-1];
    bit m_pend, n_pend;
    int m_stall, m_flush, n_stall, n_flush;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit writes(input int k);
        return (m_v[k] != 0) && (m_wr[k] != 0) && (m_rd[k] != 0);
    endfunction

    function automatic int youngest(input int rs, input bit used);
        if (!id_valid || !used || rs == 0) return 0;
        for (int k = 1; k < NR; k++) begin
            if (writes(k) && !(k == 1 && m_ld[1] != 0) && m_rd[k] == rs) return k;
        end
        return 0;
    endfunction

    task automatic set_id(input bit v, input int rs1, input bit u1, input int rs2,
                          input bit u2, input int rd, input bit wr, input bit ld);
        id_valid    = v;
        id_rs1_idx  = IW'(rs1);
        id_rs1_used = u1;
        id_rs2_idx  = IW'(rs2);
        id_rs2_used = u2;
        id_rd_idx   = IW'(rd);
        id_reg_wr   = wr;
        id_rd_mem   = ld;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 1; k < NR; k++) begin
            m_v[k] = 0; m_rd[k] = 0; m_wr[k] = 0; m_ld[k] = 0;
            n_v[k] = 0; n_rd[k] = 0; n_wr[k] = 0; n_ld[k] = 0;
        end
        m_pend = 0; n_pend = 0;
        m_stall = 0; m_flush = 0; n_stall = 0; n_flush = 0;

        rst      = 1'b0;
        br_take  = 1'b0;
        mem_busy = 1'b1;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);

        fork
            // Model state update, asynchronous clear.
            forever begin
                @(posedge clk or negedge rst);
                for (int k = 1; k < NR; k++) begin
                    m_v[k]  = rst ? n_v[k]  : 0;
                    m_rd[k] = rst ? n_rd[k] : 0;
                    m_wr[k] = rst ? n_wr[k] : 0;
                    m_ld[k] = rst ? n_ld[k] : 0;
                end
                m_pend  = rst ? n_pend  : 0;
                m_stall = rst ? n_stall : 0;
                m_flush = rst ? n_flush : 0;
            end
            // Prediction and comparison every cycle.
            forever begin
                int e_pc, e_en, e_bub, e_fa, e_fb;
                bit lu, fl, st;
                @(negedge clk);
                e_pc = 1; e_en = (1 << NR) - 1; e_bub = 0; e_fa = 0; e_fb = 0;
                if (!rst) begin
                    for (int k = 1; k < NR; k++) begin
                        n_v[k] = 0; n_rd[k] = 0; n_wr[k] = 0; n_ld[k] = 0;
                    end
                    n_pend = 0; n_stall = 0; n_flush = 0;
                end else begin
                    lu = id_valid && writes(1) && m_ld[1] != 0 &&
                         ((id_rs1_used && id_rs1_idx == m_rd[1]) ||
                          (id_rs2_used && id_rs2_idx == m_rd[1]));
                    fl = !mem_busy && (br_take || m_pend);
                    st = !mem_busy && !fl && lu;
                    if (mem_busy) begin
                        e_pc = 0; e_en = 0;
                    end else if (fl) begin
                        e_bub = (1 << BR) - 1;
                    end else if (st) begin
                        e_pc = 0; e_en = ((1 << NR) - 1) & ~1; e_bub = 2;
                    end
                    e_fa = youngest(id_rs1_idx, id_rs1_used);
                    e_fb = youngest(id_rs2_idx, id_rs2_used);
                    if (mem_busy) begin
                        for (int k = 1; k < NR; k++) begin
                            n_v[k] = m_v[k]; n_rd[k] = m_rd[k];
                            n_wr[k] = m_wr[k]; n_ld[k] = m_ld[k];
                        end
                        n_pend = m_pend || br_take;
                    end else begin
                        // Everything moves one register down the pipe.
                        for (int k = NR - 1; k >= 2; k--) begin
                            n_v[k] = m_v[k-1]; n_rd[k] = m_rd[k-1];
                            n_wr[k] = m_wr[k-1]; n_ld[k] = m_ld[k-1];
                        end
                        n_v[1] = id_valid; n_rd[1] = id_rd_idx;
                        n_wr[1] = id_reg_wr; n_ld[1] = id_rd_mem;
                        for (int k = 1; k < NR; k++) begin
                            if ((st && k == 1) || (fl && k < BR)) begin
                                n_v[k] = 0; n_rd[k] = 0; n_wr[k] = 0; n_ld[k] = 0;
                            end
                        end
                        n_pend = 0;
                    end
                    n_stall = (st && m_stall < CMAX) ? m_stall + 1 : m_stall;
                    n_flush = (fl && m_flush < CMAX) ? m_flush + 1 : m_flush;
                end
                chk("mdl_pc_enable",  pc_enable,  e_pc);
                chk("mdl_reg_enable", reg_enable, e_en);
                chk("mdl_reg_bubble", reg_bubble, e_bub);
                chk("mdl_fwd_sel_a",  fwd_sel_a,  e_fa);
                chk("mdl_fwd_sel_b",  fwd_sel_b,  e_fb);
                chk("mdl_stall_cnt",  stall_cnt,  m_stall);
                chk("mdl_flush_cnt",  flush_cnt,  m_flush);
            end
        join_none

        // Reset values hold even with mem_busy high.
        #2;
        chk("rst_pc_enable",  pc_enable,  1);
        chk("rst_reg_enable", reg_enable, 15);
        chk("rst_reg_bubble", reg_bubble, 0);
        chk("rst_stall_cnt",  stall_cnt,  0);
        chk("rst_flush_cnt",  flush_cnt,  0);
        mem_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // load x5 ; add x6,x5,x1
        set_id(1, 0, 0, 0, 0, 5, 1, 1); mid(); adv();
        set_id(1, 5, 1, 1, 1, 6, 1, 0); mid();
        chk("lu_pc_enable",  pc_enable,  0);
        chk("lu_reg_bubble", reg_bubble, 2);
        chk("lu_reg_enable", reg_enable, 14);
        chk("lu_stall_cnt0", stall_cnt,  0);
        adv(); mid();
        chk("lu_stall_cnt1", stall_cnt,  1);
        chk("lu_pc_resume",  pc_enable,  1);
        chk("lu_fwd_a2",     fwd_sel_a,  2);
        chk("lu_fwd_b0",     fwd_sel_b,  0);
        adv();

        // add x3 ; sub x7,x3,x6
        set_id(1, 0, 0, 0, 0, 3, 1, 0); mid(); adv();
        set_id(1, 3, 1, 6, 1, 7, 1, 0); mid();
        chk("alu_fwd_a1",  fwd_sel_a, 1);
        chk("alu_fwd_b2",  fwd_sel_b, 2);
        chk("alu_nostall", pc_enable, 1);
        adv();
        set_id(1, 3, 1, 0, 0, 3, 1, 0); mid();
        chk("alu_fwd_a_reg2", fwd_sel_a, 2);
        adv();
        // x3 now in registers 1 and 3: youngest wins
        set_id(1, 3, 1, 7, 1, 8, 1, 0); mid();
        chk("youngest_fwd_a", fwd_sel_a, 1);
        chk("youngest_fwd_b", fwd_sel_b, 2);
        adv();

        // load to x0 ; read x0
        set_id(1, 0, 0, 0, 0, 0, 1, 1); mid(); adv();
        set_id(1, 0, 1, 0, 1, 0, 0, 0); mid();
        chk("x0_fwd_a",  fwd_sel_a,  0);
        chk("x0_fwd_b",  fwd_sel_b,  0);
        chk("x0_pc",     pc_enable,  1);
        chk("x0_bubble", reg_bubble, 0);
        adv();

        // load x9 ; dependent reader together with taken branch
        set_id(1, 0, 0, 0, 0, 9, 1, 1); mid(); adv();
        set_id(1, 1, 1, 9, 1, 10, 1, 0); br_take = 1'b1; mid();
        chk("brlu_bubble", reg_bubble, 3);
        chk("brlu_pc",     pc_enable,  1);
        chk("brlu_enable", reg_enable, 15);
        adv(); br_take = 1'b0;
        set_id(1, 9, 1, 0, 0, 11, 1, 0); mid();
        chk("brlu_flush_cnt", flush_cnt, 1);
        chk("brlu_stall_cnt", stall_cnt, 1);
        chk("brlu_fwd_a",     fwd_sel_a, 2);
        adv();

        // freeze for 3 cycles with a taken branch and a load-use pending
        set_id(1, 0, 0, 0, 0, 4, 1, 1); mid(); adv();
        set_id(1, 4, 1, 11, 1, 12, 1, 0); br_take = 1'b1; mem_busy = 1'b1;
        repeat (3) begin
            mid();
            chk("frz_pc",       pc_enable,  0);
            chk("frz_enable",   reg_enable, 0);
            chk("frz_bubble",   reg_bubble, 0);
            chk("frz_fwd_b",    fwd_sel_b,  2);
            chk("frz_fwd_a",    fwd_sel_a,  0);
            chk("frz_flush_cnt", flush_cnt, 1);
            adv();
        end
        mem_busy = 1'b0; mid();
        chk("frz_rel_bubble", reg_bubble, 3);
        chk("frz_rel_pc",     pc_enable,  1);
        chk("frz_rel_enable", reg_enable, 15);
        adv(); br_take = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0); mid();
        chk("frz_flush_cnt2", flush_cnt, 2);
        chk("frz_stall_cnt",  stall_cnt, 1);
        adv(); mid();
        chk("frz_flush_once", flush_cnt, 2);
        adv();

        // 20 more load-use stalls saturate the 4-bit counter
        repeat (20) begin
            set_id(1, 0, 0, 0, 0, 5, 1, 1); mid(); adv();
            set_id(1, 5, 1, 0, 0, 6, 1, 0); mid(); adv();
            mid(); adv();
        end
        set_id(0, 0, 0, 0, 0, 0, 0, 0); mid();
        chk("sat_stall_cnt", stall_cnt, 15);
        adv();

        // reset in the middle of a stall
        set_id(1, 0, 0, 0, 0, 5, 1, 1); mid(); adv();
        set_id(1, 5, 1, 0, 0, 6, 1, 0); mid();
        chk("mid_stall_pc", pc_enable, 0);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_pc",     pc_enable,  1);
        chk("mid_rst_stall",  stall_cnt,  0);
        chk("mid_rst_flush",  flush_cnt,  0);
        chk("mid_rst_enable", reg_enable, 15);
        chk("mid_rst_bubble", reg_bubble, 0);
        chk("mid_rst_fwd_a",  fwd_sel_a,  0);
        @(posedge clk);
        #1 rst = 1'b1;
        mid();
        chk("post_rst_pc",     pc_enable,  1);
        chk("post_rst_bubble", reg_bubble, 0);
        adv();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
